// File: rtl/rr_packet_scheduler.sv
// Packet-locked round-robin scheduler for one router output port.
// Ports: clk, rst_n, req, req_tail, out_ready -> grant, grant_idx, grant_valid, out_valid, xfer, starve_err (RR_STARVE_MON_EN).
module rr_packet_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = $clog2(NUM_REQ),
  parameter int STARVE_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_tail,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               out_valid,
  output logic               xfer,
  output logic [NUM_REQ-1:0] starve_err
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   grant_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     last_q;
  logic [NUM_REQ-1:0]   hi;
  logic [IDX_W-1:0]     win_hi;
  logic [IDX_W-1:0]     win_lo;
  logic [IDX_W-1:0]     winner;
  logic                 found;
  logic                 tail_xfer;

  // Rotating pick: lowest request above last_q, else lowest overall.
  always_comb begin
    hi     = '0;
    win_hi = '0;
    win_lo = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi[i] = req[i] && (i > int'(last_q));
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hi[i])  win_hi = IDX_W'(i);
      if (req[i]) win_lo = IDX_W'(i);
    end
    winner = (|hi) ? win_hi : win_lo;
  end

  always_comb begin
    grant_d         = '0;
    grant_d[winner] = 1'b1;
  end

  assign found       = |req;
  assign grant_valid = (state_q == BUSY);
  assign out_valid   = grant_valid & req[idx_q];
  assign xfer        = out_valid & out_ready;
  assign tail_xfer   = xfer & req_tail[idx_q];
  assign grant       = grant_q;
  assign grant_idx   = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= BUSY;
            grant_q <= grant_d;
            idx_q   <= winner;
            last_q  <= winner;
          end
        end
        BUSY: begin
          // Locked until the tail flit is accepted; then
          // re-arbitrate in the same cycle so there is no bubble.
          if (tail_xfer) begin
            if (found) begin
              grant_q <= grant_d;
              idx_q   <= winner;
              last_q  <= winner;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              idx_q   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RR_STARVE_MON_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_REQ-1:0]            err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q[i] || !req[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != LIM) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
        // Sticky until the requester is finally served.
        if (grant_q[i]) begin
          err_q[i] <= 1'b0;
        end else if (cnt_q[i] == LIM) begin
          err_q[i] <= 1'b1;
        end
      end
    end
  end

  assign starve_err = err_q;
`else
  logic unused_limit;
  assign unused_limit = (STARVE_LIMIT > 0);
  assign starve_err   = '0;
`endif

endmodule

// File: tb/tb_rr_packet_scheduler.sv
// Self-checking bench for rr_packet_scheduler.
// Directed scenarios plus random traffic against a queue-free rotation model.
module tb_rr_packet_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int SL = 4;
`ifdef RR_STARVE_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_tail = '0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          out_valid;
  logic          xfer;
  logic [N-1:0]  starve_err;

  int errors = 0;
  int checks = 0;

  bit m_busy;
  int m_own;
  int m_last;
  int m_cnt[N];
  bit m_err[N];

  rr_packet_scheduler #(
    .NUM_REQ(N),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_tail(req_tail),
    .out_ready(out_ready),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid),
    .out_valid(out_valid),
    .xfer(xfer),
    .starve_err(starve_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL onehot: grant=%b", grant);
      end
    end
  end

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] e_grant();
    return m_busy ? (N'(1) << m_own) : '0;
  endfunction

  function automatic logic [IW-1:0] e_idx();
    return m_busy ? IW'(m_own) : '0;
  endfunction

  function automatic logic e_ov();
    return m_busy && req[m_own];
  endfunction

  function automatic logic e_xfer();
    return e_ov() && out_ready;
  endfunction

  function automatic logic [N-1:0] e_starve();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = MON && m_err[i];
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_own  = 0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_err[i] = 1'b0;
    end
  endtask

  task automatic step();
    bit nb;
    int no;
    int nl;
    int w;
    int nc[N];
    bit ne[N];
    nb = m_busy;
    no = m_own;
    nl = m_last;
    for (int i = 0; i < N; i++) begin
      bit gi;
      gi = m_busy && (m_own == i);
      ne[i] = gi ? 1'b0 : (m_err[i] || (m_cnt[i] == SL));
      if (gi || !req[i]) nc[i] = 0;
      else nc[i] = (m_cnt[i] < SL) ? m_cnt[i] + 1 : SL;
    end
    w = pick();
    if (!m_busy) begin
      if (w >= 0) begin
        nb = 1'b1;
        no = w;
        nl = w;
      end
    end else if (e_xfer() && req_tail[m_own]) begin
      if (w >= 0) begin
        no = w;
        nl = w;
      end else begin
        nb = 1'b0;
        no = 0;
      end
    end
    @(posedge clk);
    m_busy = nb;
    m_own  = no;
    m_last = nl;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = nc[i];
      m_err[i] = ne[i];
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    req_tail = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== '0 || grant_idx !== '0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: grant=%b idx=%0d gv=%b want 0", grant, grant_idx, grant_valid);
    end
    checks++;
    if (out_valid !== 1'b0 || xfer !== 1'b0 || starve_err !== '0) begin
      errors++;
      $display("FAIL reset_out: ov=%b xfer=%b se=%b want 0", out_valid, xfer, starve_err);
    end
    repeat (2) begin
      step();
      checks++;
      if (grant_valid !== 1'b0 || grant !== '0) begin
        errors++;
        $display("FAIL idle_hold: gv=%b grant=%b want 0", grant_valid, grant);
      end
    end
  endtask

  task automatic test_rotation();
    int seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    req_tail = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (grant_idx !== IW'(seq[i]) || grant !== e_grant() || xfer !== 1'b1) begin
        errors++;
        $display("FAIL rotation[%0d]: idx=%0d grant=%b xfer=%b want idx=%0d grant=%b xfer=1",
                 i, grant_idx, grant, xfer, seq[i], e_grant());
      end
    end
  endtask

  task automatic test_long_packet();
    do_reset();
    req = 4'b0100;
    req_tail = '0;
    out_ready = 1'b1;
    step();
    req = 4'b0111;
    for (int f = 1; f <= 5; f++) begin
      req_tail = (f == 5) ? 4'b0100 : 4'b0000;
      #1;
      checks++;
      if (grant_idx !== 2'd2 || xfer !== 1'b1 || xfer !== e_xfer()) begin
        errors++;
        $display("FAIL long_flit[%0d]: idx=%0d xfer=%b want idx=2 xfer=1", f, grant_idx, xfer);
      end
      step();
    end
    checks++;
    if (grant_idx !== 2'd0 || grant !== e_grant()) begin
      errors++;
      $display("FAIL long_next: idx=%0d grant=%b want idx=0 grant=%b", grant_idx, grant, e_grant());
    end
  endtask

  task automatic test_stall();
    do_reset();
    req = 4'b0010;
    req_tail = '0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (xfer !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_xfer[%0d]: xfer=%b ov=%b want xfer=0 ov=1", c, xfer, out_valid);
      end
      step();
      checks++;
      if (grant_idx !== 2'd1 || grant !== e_grant()) begin
        errors++;
        $display("FAIL stall_hold[%0d]: idx=%0d want 1", c, grant_idx);
      end
    end
    out_ready = 1'b1;
    req = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || xfer !== 1'b0) begin
        errors++;
        $display("FAIL drop_out[%0d]: ov=%b xfer=%b want 0", c, out_valid, xfer);
      end
      step();
      checks++;
      if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
        errors++;
        $display("FAIL drop_hold[%0d]: grant=%b want 0010", c, grant);
      end
    end
    req = 4'b0010;
    #1;
    checks++;
    if (grant !== 4'b0010 || xfer !== 1'b1) begin
      errors++;
      $display("FAIL req_return: grant=%b xfer=%b want 0010 1", grant, xfer);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b1000;
    req_tail = 4'b1000;
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      step();
      checks++;
      if (grant_idx !== 2'd3 || xfer !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: idx=%0d xfer=%b want 3 1", p, grant_idx, xfer);
      end
    end
    req = '0;
    req_tail = '0;
    repeat (2) begin
      step();
      checks++;
      if (grant !== e_grant() || grant_valid !== m_busy || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_drain: grant=%b gv=%b ov=%b want %b %b 0",
                 grant, grant_valid, out_valid, e_grant(), m_busy);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    req_tail = '0;
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (grant_idx !== 2'd2) begin
      errors++;
      $display("FAIL ar_pre: idx=%0d want 2", grant_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || grant_valid !== 1'b0 || grant_idx !== '0) begin
      errors++;
      $display("FAIL ar_async: grant=%b gv=%b idx=%0d want 0", grant, grant_valid, grant_idx);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0110;
    req_tail = '0;
    step();
    checks++;
    if (grant_idx !== 2'd1 || grant !== e_grant()) begin
      errors++;
      $display("FAIL ar_first: idx=%0d grant=%b want idx=1", grant_idx, grant);
    end
  endtask

  task automatic test_starve();
    do_reset();
    req = 4'b0001;
    req_tail = '0;
    out_ready = 1'b1;
    step();
    req = 4'b0011;
    for (int f = 1; f <= 14; f++) begin
      req_tail = (f == 10) ? 4'b0001 : 4'b0000;
      if (f > 10) req_tail = 4'b0010;
      #1;
      checks++;
      if (starve_err !== e_starve()) begin
        errors++;
        $display("FAIL starve[%0d]: se=%b want %b", f, starve_err, e_starve());
      end
      step();
      checks++;
      if (grant !== e_grant()) begin
        errors++;
        $display("FAIL starve_grant[%0d]: grant=%b want %b", f, grant, e_grant());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom);
      req_tail = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (out_valid !== e_ov() || xfer !== e_xfer() || starve_err !== e_starve()) begin
        errors++;
        $display("FAIL rnd_comb[%0d]: ov=%b xfer=%b se=%b want %b %b %b",
                 c, out_valid, xfer, starve_err, e_ov(), e_xfer(), e_starve());
      end
      step();
      checks++;
      if (grant !== e_grant() || grant_idx !== e_idx() || grant_valid !== m_busy) begin
        errors++;
        $display("FAIL rnd_reg[%0d]: grant=%b idx=%0d gv=%b want %b %0d %b",
                 c, grant, grant_idx, grant_valid, e_grant(), e_idx(), m_busy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_long_packet();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_starve();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
